// File: rtl/inv_bist_checker.sv
// Built-in self-test engine for an inverter array: applies vectors, waits, samples, counts mismatches.
// Optional INV_BIST_LFSR_EN replaces the alternating 0/1 pattern with a 16-bit Galois LFSR sequence.
module inv_bist_checker #(
  parameter  int WIDTH         = 1,
  parameter  int NUM_VECTORS   = 4,
  parameter  int SETTLE_CYCLES = 2,
  parameter  int ERR_CNT_W     = 8,
  localparam int VEC_W         = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     dut_a,
  input  logic [WIDTH-1:0]     dut_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 fail_valid,
  output logic [VEC_W-1:0]     fail_vec
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t           state;
  logic [VEC_W-1:0] vec_idx;
  logic [SET_W-1:0] settle_cnt;
  logic             accept;
  logic             last_vec;
  logic             settled;
  logic             mismatch;
  logic [WIDTH-1:0] first_vec;
  logic [WIDTH-1:0] next_vec;

  assign accept   = start && (state == IDLE || state == DONE);
  assign last_vec = (vec_idx == VEC_W'(NUM_VECTORS - 1));
  assign settled  = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));
  assign mismatch = (dut_y != ~dut_a);

`ifdef INV_BIST_LFSR_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  logic [15:0] lfsr;
  logic [15:0] lfsr_next;

  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
  assign first_vec = LFSR_SEED[WIDTH-1:0];
  assign next_vec  = lfsr_next[WIDTH-1:0];

  // The register holds the value that produced the current dut_a, so the next vector is one step ahead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= '0;
    end else if (accept) begin
      lfsr <= LFSR_SEED;
    end else if (state == SAMPLE && !last_vec) begin
      lfsr <= lfsr_next;
    end
  end
`else
  // Vector k is all-ones for odd k; the upcoming index vec_idx+1 is odd exactly when vec_idx is even.
  assign first_vec = '0;
  assign next_vec  = {WIDTH{~vec_idx[0]}};
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec_idx    <= '0;
      settle_cnt <= '0;
      dut_a      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dut_a      <= first_vec;
            vec_idx    <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + SET_W'(1);
          if (settled) state <= SAMPLE;
        end
        SAMPLE: begin
          if (mismatch) begin
            if (!(&err_count)) err_count <= err_count + ERR_CNT_W'(1);
            if (!fail_valid) begin
              fail_vec   <= vec_idx;
              fail_valid <= 1'b1;
            end
          end
          if (last_vec) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !fail_valid && !mismatch;
          end else begin
            vec_idx    <= vec_idx + VEC_W'(1);
            dut_a      <= next_vec;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/inv_bist_checker.md
Name: inv_bist_checker

Overview:
- Synthesizable built-in self-test engine for an inverter array. It drives stimulus vectors into a combinational inverter DUT, waits a programmable settle time, then samples the DUT output.
- Each sample is checked against the bitwise complement of the applied vector, and mismatches are counted.
- Sits beside the inverter instance, so the same directed checks run on silicon/FPGA without a simulator.

Parameters:
- WIDTH, 1, number of inverter bits driven and checked (1..16).
- NUM_VECTORS, 4, vectors applied per run (>=1).
- SETTLE_CYCLES, 2, clock cycles the vector is held before sampling (>=1).
- ERR_CNT_W, 8, width of the saturating mismatch counter.
- Localparam VEC_W = max(1, clog2(NUM_VECTORS)).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  run request, sampled on clk.
- dut_a  output  WIDTH  stimulus to inverter input, registered.
- dut_y  input  WIDTH  inverter output under check.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next accepted start.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  ERR_CNT_W  mismatching vectors this run; saturates at all-ones.
- fail_valid  output  1  at least one mismatch this run.
- fail_vec  output  VEC_W  index of the first mismatching vector.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous, active-low (rst_n); all flops clear immediately on assertion.
  - Reset values: dut_a=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, state=IDLE, vec_idx=0, settle_cnt=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- Start acceptance:
  - Accepted only in IDLE or DONE; ignored in SETTLE and SAMPLE.
  - On acceptance: dut_a<=vector(0), vec_idx<=0, settle_cnt<=0, err_count<=0, fail_valid<=0, fail_vec<=0, done<=0, pass<=0, busy<=1, state<=SETTLE.
- SETTLE:
  - settle_cnt increments every cycle.
  - When settle_cnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (one cycle):
  - mismatch = (dut_y != ~dut_a) over all WIDTH bits.
  - On mismatch: err_count increments unless all-ones.
  - On mismatch with fail_valid=0: fail_vec<=vec_idx and fail_valid<=1.
  - If vec_idx==NUM_VECTORS-1: state<=DONE, busy<=0, done<=1, pass<=(no mismatches including this sample).
  - Otherwise: vec_idx++, dut_a<=vector(vec_idx+1), settle_cnt<=0, state<=SETTLE.
- Timing:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - done rises NUM_VECTORS*(SETTLE_CYCLES+1) edges after the start-accept edge; 12 with defaults.
- DONE: results and dut_a are held until a new start is accepted or reset.
- Default vector pattern: vector(k) = all-zeros for even k, all-ones for odd k (0,1,0,1...).
- Reset mid-run: the run is abandoned and all outputs take reset values; no partial result is retained.
- start held high: a new run starts on the first edge in DONE, i.e. back-to-back runs.

Optional Feature:
- Macro: INV_BIST_LFSR_EN.
- Defined:
  - vector(k) = low WIDTH bits of a 16-bit Galois LFSR (taps 0xB400), reloaded with seed 0xACE1 on each accepted start and advanced once per SAMPLE→SETTLE transition.
  - vector(0) = low WIDTH bits of 0xACE1.
- Undefined: the alternating all-zeros/all-ones pattern; no LFSR logic is synthesized.

Test Plan:
- Ideal inverter (dut_y=~dut_a), defaults, start pulse -> dut_a sequence 0,1,0,1; done at +12 cycles; pass=1; err_count=0; fail_valid=0.
- dut_y stuck at 0 -> err_count=2, fail_vec=0, fail_valid=1, pass=0.
- Buffer DUT (dut_y=dut_a), WIDTH=4 -> err_count=4, fail_vec=0; dut_a alternates 4'h0/4'hF.
- start pulsed in cycle 5 of a run -> ignored; done still at +12 with unchanged results.
- rst_n low at cycle 7 of a run -> all outputs 0 immediately; a fresh start then completes with pass=1.
- NUM_VECTORS=300, ERR_CNT_W=8, buffer DUT -> err_count saturates at 255; with INV_BIST_LFSR_EN, first dut_a = 0x1 (WIDTH=1, seed 0xACE1).
